// File: rtl/vram_rect_writer_pkg.sv
// Shared constants for the VRAM rectangle writer.
// Screen geometry (640x480), VRAM address/data widths and the colour
// constants used by the write engine.
package vram_rect_writer_pkg;

    localparam int unsigned H_RES   = 640;
    localparam int unsigned V_RES   = 480;
    localparam int unsigned VRAM_AW = 19;
    localparam int unsigned COLOR_W = 9;

    localparam logic [COLOR_W-1:0] BLACK = 9'h000;
    localparam logic [COLOR_W-1:0] WHITE = 9'h1FF;

endpackage

// File: rtl/vram_rect_writer_clip.sv
// Clips one axis of a rectangle against the screen edge.
//   pos     : start coordinate (column or line)
//   len     : requested extent along this axis
//   clipped : min(len, LIMIT - pos); meaningless when empty is set
//   empty   : start lies off-screen or the extent is zero
module vram_rect_writer_clip #(
    parameter int unsigned LIMIT = 640
) (
    input  logic [9:0] pos,
    input  logic [9:0] len,
    output logic [9:0] clipped,
    output logic       empty
);

    logic [10:0] room;

    always_comb begin
        empty   = (32'(pos) >= LIMIT) || (len == '0);
        room    = 11'(LIMIT) - {1'b0, pos};
        clipped = ({1'b0, len} < room) ? len : room[9:0];
    end

endmodule

// File: rtl/vram_rect_writer.sv
// Rectangle-fill engine driving port B of the 640x480x9 VRAM.
// Accepts one fill command over valid/ready, writes one clipped pixel per
// clock on port B, then pulses done for one cycle.
//   clk_25mhz, RST_N      : pixel clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   : command handshake (ready high only in IDLE)
//   cmd_x/y/w/h/color     : rectangle origin, size and RRRGGGBBB colour
//   vga_end               : end-of-frame pulse (used when WAIT_VEND=1)
//   vram_adrb/dinb/web    : VRAM port-B write interface (registered)
//   busy, done            : engine activity and completion pulse
module vram_rect_writer #(
    parameter int unsigned H_RES     = vram_rect_writer_pkg::H_RES,
    parameter int unsigned V_RES     = vram_rect_writer_pkg::V_RES,
    parameter bit          WAIT_VEND = 1'b0
) (
    input  logic        clk_25mhz,
    input  logic        RST_N,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_x,
    input  logic [9:0]  cmd_y,
    input  logic [9:0]  cmd_w,
    input  logic [9:0]  cmd_h,
    input  logic [8:0]  cmd_color,
    input  logic        vga_end,
    output logic [18:0] vram_adrb,
    output logic [8:0]  vram_dinb,
    output logic        vram_web,
    output logic        busy,
    output logic        done
);

    import vram_rect_writer_pkg::*;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] SYNC  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [VRAM_AW-1:0] ROW_STRIDE = VRAM_AW'(H_RES);

    logic [2:0]         state;
    logic [9:0]         x_q, y_q, w_q, h_q;
    logic [COLOR_W-1:0] color_q;
    logic [9:0]         wc_q, hc_q, col, row;
    logic [VRAM_AW-1:0] row_base;

    logic [9:0]         wc_c, hc_c;
    logic               empty_h, empty_v;
    logic [VRAM_AW-1:0] base_c;
    logic [9:0]         col_next, row_next;
    logic               start_write;

    vram_rect_writer_clip #(.LIMIT(H_RES)) u_clip_h (
        .pos     (x_q),
        .len     (w_q),
        .clipped (wc_c),
        .empty   (empty_h)
    );

    vram_rect_writer_clip #(.LIMIT(V_RES)) u_clip_v (
        .pos     (y_q),
        .len     (h_q),
        .clipped (hc_c),
        .empty   (empty_v)
    );

    // y*640 + x as shifts: 640 = 512 + 128. Only valid for a 640-wide screen.
    assign base_c   = {y_q, 9'b0} + {2'b0, y_q, 7'b0} + {9'b0, x_q};
    assign col_next = col + 10'd1;
    assign row_next = row + 10'd1;

    // Entry into WRITE loads the first pixel onto the port in the same edge,
    // from either SETUP (no frame sync) or SYNC (on the vga_end pulse).
    always_comb begin
        start_write = 1'b0;
        if (state == SETUP) begin
            start_write = !(empty_h || empty_v) && !WAIT_VEND;
        end else if (state == SYNC) begin
            start_write = vga_end;
        end
    end

    always_ff @(posedge clk_25mhz or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            vram_web  <= 1'b0;
            vram_adrb <= '0;
            vram_dinb <= BLACK;
            x_q       <= '0;
            y_q       <= '0;
            w_q       <= '0;
            h_q       <= '0;
            color_q   <= '0;
            wc_q      <= '0;
            hc_q      <= '0;
            col       <= '0;
            row       <= '0;
            row_base  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        x_q       <= cmd_x;
                        y_q       <= cmd_y;
                        w_q       <= cmd_w;
                        h_q       <= cmd_h;
                        color_q   <= cmd_color;
                        state     <= SETUP;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                SETUP: begin
                    wc_q <= wc_c;
                    hc_q <= hc_c;
                    if (empty_h || empty_v) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (WAIT_VEND) begin
                        state <= SYNC;
                    end
                end
                SYNC: begin
                end
                WRITE: begin
                    if (col == wc_q - 10'd1) begin
                        if (row == hc_q - 10'd1) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            vram_web <= 1'b0;
                        end else begin
                            col       <= '0;
                            row       <= row_next;
                            row_base  <= row_base + ROW_STRIDE;
                            vram_adrb <= row_base + ROW_STRIDE;
                        end
                    end else begin
                        col       <= col_next;
                        vram_adrb <= row_base + {9'b0, col_next};
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase

            if (start_write) begin
                state     <= WRITE;
                vram_web  <= 1'b1;
                vram_dinb <= color_q;
                vram_adrb <= base_c;
                row_base  <= base_c;
                col       <= '0;
                row       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vram_rect_writer.sv
// Self-checking bench for vram_rect_writer: two instances (no frame sync and
// frame sync), directed corner cases plus random fills compared against a
// pixel-list reference model built from the clipping rules.
module tb_vram_rect_writer;

    localparam int HR = 640;
    localparam int VR = 480;

    logic        clk_25mhz = 1'b0;
    logic        RST_N     = 1'b0;
    logic        cv0, cv1;
    logic [9:0]  cmd_x, cmd_y, cmd_w, cmd_h;
    logic [8:0]  cmd_color;
    logic        vga_end;

    logic        ready0, web0, busy0, done0;
    logic [18:0] adrb0;
    logic [8:0]  dinb0;
    logic        ready1, web1, busy1, done1;
    logic [18:0] adrb1;
    logic [8:0]  dinb1;

    logic        sel;
    logic        obs_ready, obs_web, obs_busy, obs_done;
    logic [18:0] obs_adrb;
    logic [8:0]  obs_dinb;

    int vectors    = 0;
    int miscompares = 0;
    int unsigned exp_q[$];
    int unsigned got_q[$];

    always #20 clk_25mhz = ~clk_25mhz;

    vram_rect_writer dut (
        .clk_25mhz (clk_25mhz), .RST_N (RST_N),
        .cmd_valid (cv0), .cmd_ready (ready0),
        .cmd_x (cmd_x), .cmd_y (cmd_y), .cmd_w (cmd_w), .cmd_h (cmd_h),
        .cmd_color (cmd_color), .vga_end (vga_end),
        .vram_adrb (adrb0), .vram_dinb (dinb0), .vram_web (web0),
        .busy (busy0), .done (done0)
    );

    vram_rect_writer #(.WAIT_VEND(1'b1)) dut_v (
        .clk_25mhz (clk_25mhz), .RST_N (RST_N),
        .cmd_valid (cv1), .cmd_ready (ready1),
        .cmd_x (cmd_x), .cmd_y (cmd_y), .cmd_w (cmd_w), .cmd_h (cmd_h),
        .cmd_color (cmd_color), .vga_end (vga_end),
        .vram_adrb (adrb1), .vram_dinb (dinb1), .vram_web (web1),
        .busy (busy1), .done (done1)
    );

    always_comb begin
        if (sel) begin
            obs_ready = ready1; obs_web = web1; obs_busy = busy1;
            obs_done  = done1;  obs_adrb = adrb1; obs_dinb = dinb1;
        end else begin
            obs_ready = ready0; obs_web = web0; obs_busy = busy0;
            obs_done  = done0;  obs_adrb = adrb0; obs_dinb = dinb0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: every on-screen pixel of the requested rectangle, raster order.
    task automatic build_exp(input int x, input int y, input int w, input int h);
        exp_q.delete();
        for (int r = y; r < y + h; r++)
            for (int c = x; c < x + w; c++)
                if (r < VR && c < HR) exp_q.push_back(r * HR + c);
    endtask

    task automatic scramble();
        cmd_x     = 10'($urandom);
        cmd_y     = 10'($urandom);
        cmd_w     = 10'($urandom);
        cmd_h     = 10'($urandom);
        cmd_color = 9'($urandom);
    endtask

    // k counts sample points taken 1 time unit after the k-th edge following
    // the acceptance edge (k=0 is the SETUP cycle).
    task automatic run_cmd(input int x, input int y, input int w, input int h,
                           input logic [8:0] color, input int vend_at,
                           input bit hold, input string name);
        int n, f, limit, first_k, last_k, done_k;
        bit ready_bad, din_bad;
        build_exp(x, y, w, h);
        n = exp_q.size();
        got_q.delete();
        sel = (vend_at >= 0);
        f   = sel ? vend_at + 1 : 1;
        cmd_x = 10'(x); cmd_y = 10'(y); cmd_w = 10'(w); cmd_h = 10'(h);
        cmd_color = color;
        if (sel) cv1 = 1'b1; else cv0 = 1'b1;
        #1;
        check({name, "/ready_idle"}, 32'(obs_ready), 1);
        @(posedge clk_25mhz); #1;
        if (!hold) begin cv0 = 1'b0; cv1 = 1'b0; end
        scramble();
        vga_end = sel;  // a pulse during SETUP must not release the sync wait
        check({name, "/ready_setup"}, 32'(obs_ready), 0);
        check({name, "/busy_setup"}, 32'(obs_busy), 1);
        check({name, "/web_setup"}, 32'(obs_web), 0);
        first_k = -1; last_k = -1; done_k = -1; ready_bad = 0; din_bad = 0;
        limit = f + n + 8;
        for (int k = 1; k <= limit && done_k < 0; k++) begin
            @(posedge clk_25mhz); #1;
            vga_end = sel && (k == vend_at);
            scramble();
            if (obs_ready !== 1'b0) ready_bad = 1;
            if (obs_web === 1'b1) begin
                if (first_k < 0) first_k = k;
                last_k = k;
                got_q.push_back(32'(obs_adrb));
                if (obs_dinb !== color) din_bad = 1;
            end
            if (obs_done === 1'b1) done_k = k;
        end
        vga_end = 1'b0;
        check({name, "/done_seen"}, 32'(done_k >= 0), 1);
        check({name, "/write_count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++)
            check({name, "/addr"}, got_q[i], exp_q[i]);
        if (n > 0) begin
            check({name, "/first_write"}, first_k, f);
            check({name, "/last_write"}, last_k, f + n - 1);
            check({name, "/dinb"}, 32'(din_bad), 0);
        end
        check({name, "/done_cycle"}, done_k, (n > 0) ? f + n : 1);
        check({name, "/ready_busy"}, 32'(ready_bad), 0);
        @(posedge clk_25mhz); #1;
        check({name, "/ready_after"}, 32'(obs_ready), 1);
        check({name, "/busy_after"}, 32'(obs_busy), 0);
        check({name, "/done_after"}, 32'(obs_done), 0);
        check({name, "/web_after"}, 32'(obs_web), 0);
    endtask

    initial begin
        cv0 = 1'b0; cv1 = 1'b0; vga_end = 1'b0; sel = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;

        // Reset state
        repeat (3) @(posedge clk_25mhz);
        #1;
        check("rst/ready", 32'(ready0), 1);
        check("rst/busy", 32'(busy0), 0);
        check("rst/web", 32'(web0), 0);
        check("rst/done", 32'(done0), 0);
        check("rst/adrb", 32'(adrb0), 0);
        check("rst/dinb", 32'(dinb0), 0);
        RST_N = 1'b1;
        @(posedge clk_25mhz); #1;
        check("rst_rel/ready", 32'(ready0), 1);
        check("rst_rel/web", 32'(web0), 0);

        // Directed corner cases
        run_cmd(0, 0, 2, 2, 9'h1C0, -1, 0, "tl2x2");
        run_cmd(638, 479, 10, 5, 9'h03F, -1, 0, "br_clip");
        run_cmd(700, 10, 4, 4, 9'h111, -1, 0, "off_x");
        run_cmd(10, 10, 0, 4, 9'h111, -1, 0, "w_zero");
        run_cmd(10, 480, 4, 4, 9'h111, -1, 0, "off_y");
        run_cmd(600, 470, 100, 100, 9'h1FF, -1, 0, "big_clip");
        run_cmd(5, 5, 3, 1, 9'h0AA, 20, 0, "vend");

        // Asynchronous reset during the 3rd pixel of a 4x4 fill
        sel = 1'b0;
        cmd_x = 10'd100; cmd_y = 10'd50; cmd_w = 10'd4; cmd_h = 10'd4;
        cmd_color = 9'h155; cv0 = 1'b1;
        @(posedge clk_25mhz); #1;
        cv0 = 1'b0;
        repeat (3) @(posedge clk_25mhz);
        #1;
        check("midrst/pix3_web", 32'(web0), 1);
        check("midrst/pix3_adr", 32'(adrb0), 50 * HR + 102);
        #2 RST_N = 1'b0;
        #1;
        check("midrst/web", 32'(web0), 0);
        check("midrst/busy", 32'(busy0), 0);
        check("midrst/ready", 32'(ready0), 1);
        check("midrst/adrb", 32'(adrb0), 0);
        repeat (2) @(posedge clk_25mhz);
        #5 RST_N = 1'b1;
        @(posedge clk_25mhz); #1;
        run_cmd(100, 50, 4, 4, 9'h0F0, -1, 0, "after_rst");

        // cmd_valid held high across two commands
        run_cmd(20, 30, 3, 2, 9'h007, -1, 1, "hold_a");
        run_cmd(40, 60, 2, 3, 9'h038, -1, 0, "hold_b");

        // Random commands, biased toward the screen edges half of the time
        for (int i = 0; i < 12; i++) begin
            int rx, ry;
            rx = (i % 2 == 0) ? int'($urandom_range(0, 700)) : int'($urandom_range(628, 645));
            ry = (i % 2 == 0) ? int'($urandom_range(0, 500)) : int'($urandom_range(470, 485));
            run_cmd(rx, ry, int'($urandom_range(0, 12)), int'($urandom_range(0, 8)),
                    9'($urandom), -1, 0, "rand");
        end
        for (int i = 0; i < 3; i++) begin
            run_cmd(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                    int'($urandom_range(1, 6)), int'($urandom_range(1, 4)),
                    9'($urandom), int'($urandom_range(2, 15)), 0, "rand_vend");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vram_rect_writer.md
Name: vram_rect_writer

Overview:
- Write-side engine for the 640x480 9-bit VRAM, driving the second port of the dual-port block RAM.
- The VGA scan-out logic reads the first port.
- Accepts one rectangle-fill command at a time over a valid/ready handshake.
- Emits one pixel write per clock on the VRAM write port, clipped to the visible screen, then pulses done.
- Optional frame sync: writes start only after the end-of-frame pulse.

Parameters:
- H_RES, 640, screen width in pixels; also the VRAM row stride.
- V_RES, 480, screen height in lines.
- WAIT_VEND, 0, if 1 an accepted command waits for the next vga_end pulse before writing.

Ports:
- clk_25mhz  in  1  pixel clock.
- RST_N  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_x  in  10  left column.
- cmd_y  in  10  top line.
- cmd_w  in  10  width in pixels.
- cmd_h  in  10  height in lines.
- cmd_color  in  9  RRRGGGBBB fill colour.
- vga_end  in  1  one-cycle end-of-frame pulse from the scan-out controller.
- vram_adrb  out  19  VRAM port-B address.
- vram_dinb  out  9  VRAM port-B write data.
- vram_web  out  1  VRAM port-B write enable.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (asynchronous, immediate, also mid-command): state=IDLE, cmd_ready=1, busy=0, done=0, vram_web=0, vram_adrb=0, vram_dinb=0. Any partially written rectangle stays as written; there is no resume.
- Handshake: transfer occurs when cmd_valid && cmd_ready on a rising edge. All cmd_* fields are latched at that edge and may change afterwards. cmd_ready is registered low from the next cycle until the return to IDLE.
- State IDLE -> SETUP on transfer.
- State SETUP (1 cycle) computes clipped values:
  - wc = min(w, H_RES - x); hc = min(h, V_RES - y).
  - Empty command if x >= H_RES, y >= V_RES, w == 0 or h == 0: go to DONE, zero writes.
  - Otherwise row_base = y*H_RES + x, computed as (y<<9)+(y<<7)+x, no multiplier. All address arithmetic is 19-bit unsigned.
  - Next state is SYNC if WAIT_VEND=1, else WRITE.
- State SYNC: hold until vga_end=1, then WRITE on the next edge. If vga_end is already high during the SETUP cycle, it is ignored; the next pulse is used.
- State WRITE: registered outputs, one pixel per cycle.
  - vram_web=1, vram_dinb=latched colour, vram_adrb=row_base+col.
  - col increments 0..wc-1.
  - On col==wc-1: col=0, row_base += H_RES, row++.
  - After the last pixel (row==hc-1, col==wc-1): go to DONE.
  - Writes are contiguous with no gaps: exactly wc*hc web-high cycles.
- State DONE (1 cycle): done=1, web=0, then IDLE. cmd_ready returns high in the cycle after done.
- Latency, WAIT_VEND=0, non-empty command, acceptance at edge N:
  - first web=1 in cycle N+2;
  - last write in cycle N+1+wc*hc;
  - done in cycle N+2+wc*hc.
- Empty command: done in cycle N+2.
- Outside WRITE: vram_web=0; vram_adrb and vram_dinb hold their last value.
- The highest legal address is 307199; clipping guarantees no address beyond it.
- No arbitration with the scan-out port. Same-address read/write collisions are tolerated by the dual-port RAM; the reader may see old or new data for that pixel.

Decomposition:
- Shared package holds: H_RES, V_RES, VRAM_AW=19, COLOR_W=9, and the 9-bit colour constants (BLACK=0, WHITE=9'h1FF).
- The state encoding (IDLE, SETUP, SYNC, WRITE, DONE) stays local.
- No sub-module required. A small combinational helper vram_clip (x, w, limit -> clipped w, empty flag) is natural; it is instantiated twice (horizontal and vertical).

Test Plan:
- x=0, y=0, w=2, h=2, colour 9'h1C0, WAIT_VEND=0 -> web high 4 cycles, addresses 0, 1, 640, 641, dinb=9'h1C0, done at N+6, cmd_ready high at N+7.
- x=638, y=479, w=10, h=5 -> clipped to 2x1; addresses 307198, 307199 only; done follows.
- x=700, y=10, w=4, h=4 (and separately w=0) -> zero web-high cycles, done at N+2.
- WAIT_VEND=1, x=5, y=5, w=3, h=1; vga_end pulsed 20 cycles after acceptance -> no writes before the pulse; addresses 3205, 3206, 3207 starting the cycle after the pulse.
- RST_N low asynchronously during the 3rd pixel of a 4x4 fill -> web=0, busy=0, cmd_ready=1 immediately. A new command accepted after release completes normally.
- cmd_valid held high across two commands -> second accepted only in the cycle after done; cmd_* changes while busy have no effect on the addresses written.
